// File: rtl/startup_pkg.sv
// Shared types and default constants for the power-up gate sequencer.
package startup_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int unsigned DEF_N_GATES      = 5;
    localparam int unsigned DEF_STAGE_CYCLES = 208_333;
    localparam int unsigned DEF_SYNC_STAGES  = 2;

endpackage

// File: rtl/startup_rst_sync.sv
// Reset synchronizer: asynchronous assert, release after SYNC_STAGES clock edges.
module startup_rst_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    output logic rst_n_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_n_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/startup.sv
// Power-up sequencer: raises gate enables one by one, STAGE_CYCLES apart, after reset release.
module startup
    import startup_pkg::*;
#(
    parameter int unsigned N_GATES      = DEF_N_GATES,
    parameter int unsigned STAGE_CYCLES = DEF_STAGE_CYCLES,
    parameter int unsigned SYNC_STAGES  = DEF_SYNC_STAGES
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    output logic [N_GATES-1:0] gate_en_o
);

    localparam int unsigned CNT_W = $clog2(STAGE_CYCLES);
    localparam int unsigned STG_W = $clog2(N_GATES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STAGE_CYCLES - 1);
    localparam logic [STG_W-1:0] STG_LAST = STG_W'(N_GATES - 1);

    logic               rst_sync_n;
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STG_W-1:0]   stage_q, stage_d;
    logic [N_GATES-1:0] gate_q, gate_d;

    startup_rst_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_rst_sync (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .rst_n_o(rst_sync_n)
    );

    // The IDLE cycle is counted as stage cycle 0, so the counter enters COUNT at 1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        gate_d  = gate_q;
        unique case (state_q)
            IDLE: begin
                state_d = COUNT;
                cnt_d   = CNT_W'(1);
            end
            COUNT: begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d   = '0;
                    stage_d = stage_q + STG_W'(1);
                    for (int unsigned k = 0; k < N_GATES; k++) begin
                        if (stage_q == STG_W'(k)) begin
                            gate_d[k] = 1'b1;
                        end
                    end
                    if (stage_q == STG_LAST) begin
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Synchronized reset still asserts asynchronously, clearing the enables at once.
    always_ff @(posedge clk_i or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            stage_q <= '0;
            gate_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            gate_q  <= gate_d;
        end
    end

    assign gate_en_o = gate_q;

endmodule

// File: tb/tb_startup.sv
// Scoreboard bench for startup: expected gate transitions queued at reset release.
module tb_startup;
    import startup_pkg::*;

    localparam int ST  = 10;
    localparam int NG  = 5;
    localparam int SS  = 2;
    localparam int LAST_EDGE = SS - 1 + NG * ST;

    typedef struct {
        int         edge_n;
        logic [4:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n_i = 1'b0;
    logic [4:0] gate;
    logic [0:0] gate1;

    int   tests = 0;
    int   fails = 0;
    int   e = -1;
    int   rst_cnt = 0;
    int   edge_seen = 0;
    int   mon_seen = 0;
    logic [4:0] prev = '0;
    exp_t sb[$];

    startup #(.N_GATES(NG), .STAGE_CYCLES(ST), .SYNC_STAGES(SS)) dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n_i),
        .gate_en_o(gate)
    );

    startup #(.N_GATES(1), .STAGE_CYCLES(2), .SYNC_STAGES(2)) dut1 (
        .clk_i    (clk),
        .rst_n_i  (rst_n_i),
        .gate_en_o(gate1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge rst_n_i) rst_cnt++;

    // Edge index: E0 is the first rising edge sampling rst_n_i high after any reset.
    always @(posedge clk) begin
        if (!rst_n_i) begin
            e = -1;
            edge_seen = rst_cnt;
        end else if (rst_cnt != edge_seen) begin
            edge_seen = rst_cnt;
            e = 0;
        end else begin
            e = e + 1;
        end
    end

    // Output monitor: invariants every cycle, transitions matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_n_i) begin
            check("no_x", 32'($isunknown(gate)), 32'd0);
            check("therm", 32'(((gate + 5'd1) & gate) == 5'd0), 32'd1);
            if (mon_seen == rst_cnt) begin
                check("one_step", 32'($countones(gate ^ prev) <= 1), 32'd1);
            end
            if (gate !== prev && gate !== 5'd0) begin
                if (sb.size() == 0) begin
                    check("unexpected", 32'(gate), 32'(prev));
                end else begin
                    exp_t it;
                    it = sb.pop_front();
                    check("edge", 32'(e), 32'(it.edge_n));
                    check("val", 32'(gate), 32'(it.val));
                end
            end
            if (e == 2) check("d1_e2", 32'(gate1), 32'd0);
            if (e == 3) check("d1_e3", 32'(gate1), 32'd1);
            if (e == 4) check("d1_done", 32'(dut1.state_q), 32'(DONE));
        end
        mon_seen = rst_cnt;
        prev = gate;
    end

    task automatic push_seq();
        exp_t it;
        int   v;
        for (int k = 0; k < NG; k++) begin
            v = (1 << (k + 1)) - 1;
            it.edge_n = SS - 1 + (k + 1) * ST;
            it.val    = 5'(v);
            sb.push_back(it);
        end
    endtask

    task automatic wait_edge(input int target);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (e < target && n < 200);
        check("timeout", 32'(e >= target), 32'd1);
    endtask

    task automatic check_done(input string tag);
        check({tag, "_gate"}, 32'(gate), 32'h1f);
        check({tag, "_sb"}, 32'(sb.size()), 32'd0);
        check({tag, "_state"}, 32'(dut.state_q), 32'(DONE));
        check({tag, "_cnt"}, 32'(dut.cnt_q), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_gate", 32'(gate), 32'd0);
        check("rst_gate1", 32'(gate1), 32'd0);
        check("rst_state", 32'(dut.state_q), 32'(IDLE));
        check("rst_cnt", 32'(dut.cnt_q), 32'd0);

        // Plain power-up run
        #2 rst_n_i = 1'b1;
        push_seq();
        wait_edge(LAST_EDGE + 5);
        check_done("run1");

        // Reset mid-sequence, between edges, while two gates are up
        @(negedge clk) rst_n_i = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n_i = 1'b1;
        push_seq();
        wait_edge(25);
        check("mid_pre", 32'(gate), 32'h03);
        #2 rst_n_i = 1'b0;
        #1 check("mid_clr", 32'(gate), 32'd0);
        check("mid_state", 32'(dut.state_q), 32'(IDLE));
        sb.delete();
        @(negedge clk);
        #2 rst_n_i = 1'b1;
        push_seq();
        wait_edge(LAST_EDGE + 5);
        check_done("run2");

        // Sub-cycle reset pulse while in DONE
        #2 rst_n_i = 1'b0;
        #1 check("pulse_clr", 32'(gate), 32'd0);
        rst_n_i = 1'b1;
        push_seq();
        wait_edge(LAST_EDGE + 5);
        check_done("run3");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/startup.md
STARTUP -- requirements
Module: startup

Interface
REQ-001 Parameter N_GATES, default 5, number of sequenced gate-enable outputs; legal range 1..16.
REQ-002 Parameter STAGE_CYCLES, default 208_333 (1 ms at 208.33 MHz, 4.8 ns period), clock cycles per stage; legal range at least 2.
REQ-003 Parameter SYNC_STAGES, default 2, depth of the reset-release synchronizer; legal range at least 2.
REQ-004 Port clk_i, input, 1 bit: the single system clock; all flops rising-edge.
REQ-005 Port rst_n_i, input, 1 bit: one clock; reset is asynchronous and active-low.
REQ-006 Port gate_en_o, output, N_GATES bits: per-domain gate enables, bit 0 enabled first.

Function
REQ-007 The block SHALL be a power-up sequencer that asserts gate_en_o bits one at a time, in ascending index order, each STAGE_CYCLES after the previous.
REQ-008 Edge E0 is the first rising clk_i edge with rst_n_i sampled high; the internal synchronized reset SHALL release at edge E(SYNC_STAGES-1).
REQ-009 gate_en_o[k] SHALL rise exactly at edge E(SYNC_STAGES-1 + (k+1)*STAGE_CYCLES), for k = 0..N_GATES-1.
REQ-010 gate_en_o SHALL always be a thermometer code (bit k set implies bits 0..k-1 set); once set, a bit SHALL stay set until reset.
REQ-011 gate_en_o SHALL be driven directly from flops; no combinational path from any input to gate_en_o.
REQ-012 The FSM SHALL have three states:
  - IDLE: reset state; move to COUNT on the first cycle the synchronized reset is released.
  - COUNT: run the stage counter; on terminal count, set the next gate bit; after the last bit, move to DONE.
  - DONE: hold all bits at 1; the counter stops.
REQ-013 Stage counter:
  - width $clog2(STAGE_CYCLES);
  - counts 0..STAGE_CYCLES-1, wraps to 0 on terminal count;
  - a stage index of width $clog2(N_GATES+1) selects the next bit to set.
REQ-014 Once in DONE, the block SHALL stay idle (no counter toggling) until the next reset.

Reset
REQ-015 While rst_n_i is low, gate_en_o SHALL be all zeros, the FSM SHALL be in IDLE, and counters SHALL be 0.
REQ-016 Assertion of rst_n_i SHALL clear gate_en_o asynchronously, with no clock edge required, including mid-sequence and in DONE.
REQ-017 Release of rst_n_i SHALL be synchronized through SYNC_STAGES flops (asynchronous assert, synchronous deassert); the full sequence SHALL then restart from bit 0.
REQ-018 A reset pulse shorter than one clock period SHALL still fully clear state and restart the sequence.

Structure
REQ-019 Package startup_pkg SHALL hold the FSM state enum (IDLE, COUNT, DONE) and the default constants for N_GATES, STAGE_CYCLES and SYNC_STAGES.
REQ-020 Sub-module startup_rst_sync (parameter SYNC_STAGES) SHALL implement the reset synchronizer; the FSM, counter and output register SHALL live in startup.

Verification
REQ-021 STAGE_CYCLES=10, N_GATES=5; release reset at edge E0 -> gate_en_o changes 00000 -> 00001 at E11, 00011 at E21, 00111 at E31, 01111 at E41, 11111 at E51, then stays constant.
REQ-022 Default parameters, clock period 4.8 ns, release reset at t=2 ns -> bits rise at about 1, 2, 3, 4 and 5 ms; gate_en_o is 11111 at t=10 ms.
REQ-023 STAGE_CYCLES=10; assert rst_n_i asynchronously between edges while gate_en_o=00011 -> gate_en_o is 00000 before the next edge; after release the sequence restarts with bit 0 at E11.
REQ-024 In DONE, assert rst_n_i for 1 ns (sub-cycle) -> gate_en_o clears immediately and the full sequence repeats with identical timing.
REQ-025 Assertions over all runs:
  - gate_en_o is always a thermometer code;
  - at most one bit changes per cycle;
  - gate_en_o is never X after reset.
REQ-026 N_GATES=1, STAGE_CYCLES=2 -> gate_en_o[0] rises at E3 and the FSM is in DONE on the following cycle.
